// File: rtl/seq_mux_pkg.sv
// rtl/seq_mux_pkg.sv - shared state encoding and default sizes for the project mux
package seq_mux_pkg;

  typedef enum logic [1:0] {IDLE, GUARD, ACTIVE} mux_state_t;

  localparam int DEF_N_PROJ    = 24;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_IW_W      = 18;
  localparam int DEF_OW_W      = 24;
  localparam int DEF_GUARD_CYC = 2;

endpackage

// File: rtl/mux_onehot_dec.sv
// rtl/mux_onehot_dec.sv - address plus valid to one-hot project vector
module mux_onehot_dec #(
  parameter int ADDR_W = 5,
  parameter int N_PROJ = 24
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              valid,
  output logic [N_PROJ-1:0] onehot
);

  // Addresses at or above N_PROJ match no slot and yield all zeros.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (valid && (addr == ADDR_W'(k))) onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_project_mux.sv
// rtl/seq_project_mux.sv - clocked project mux with guard interval on every switch
module seq_project_mux
  import seq_mux_pkg::*;
#(
  parameter int N_PROJ    = DEF_N_PROJ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int IW_W      = DEF_IW_W,
  parameter int OW_W      = DEF_OW_W,
  parameter int GUARD_CYC = DEF_GUARD_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [ADDR_W-1:0]      addr_in,
  input  logic                   addr_load,
  input  logic [IW_W-1:0]        iw,
  output logic [OW_W-1:0]        ow,
  output logic [N_PROJ-1:0]      proj_ena,
  output logic [N_PROJ*IW_W-1:0] proj_iw,
  input  logic [N_PROJ*OW_W-1:0] proj_ow,
  output logic [ADDR_W-1:0]      sel_addr,
  output logic                   busy,
  output logic                   addr_err
);

  localparam int CNT_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(GUARD_CYC - 1);
  localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W+1)'(N_PROJ);

  mux_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] sel_nxt;
  logic              err_nxt;
  logic              legal;
  logic [N_PROJ-1:0] ena_nxt;
  logic [N_PROJ-1:0] iw_gate;

  assign legal = ({1'b0, addr_in} < LIMIT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_addr;
    err_nxt   = 1'b0;
    if (!ena) begin
      state_nxt = IDLE;
    end else if (addr_load && !legal) begin
      err_nxt   = 1'b1;
      state_nxt = IDLE;
    end else if (addr_load && !(state == ACTIVE && addr_in == sel_addr)) begin
      sel_nxt   = addr_in;
      state_nxt = GUARD;
      cnt_nxt   = CNT_LOAD;
    end else if (state == GUARD) begin
      if (cnt == '0) state_nxt = ACTIVE;
      else           cnt_nxt   = cnt - 1'b1;
    end
  end

  // Enables are decoded from the next state so they change on the same edge as busy.
  mux_onehot_dec #(.ADDR_W(ADDR_W), .N_PROJ(N_PROJ)) u_dec_ena (
    .addr   (sel_nxt),
    .valid  (state_nxt == ACTIVE),
    .onehot (ena_nxt)
  );

  mux_onehot_dec #(.ADDR_W(ADDR_W), .N_PROJ(N_PROJ)) u_dec_iw (
    .addr   (sel_addr),
    .valid  (state == ACTIVE),
    .onehot (iw_gate)
  );

  for (genvar k = 0; k < N_PROJ; k++) begin : g_iw
    assign proj_iw[k*IW_W +: IW_W] = iw_gate[k] ? iw : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sel_addr <= '0;
      proj_ena <= '0;
      ow       <= '0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sel_addr <= sel_nxt;
      proj_ena <= ena_nxt;
      ow       <= (state == ACTIVE) ? proj_ow[int'(sel_addr)*OW_W +: OW_W] : '0;
      busy     <= (state_nxt == GUARD);
      addr_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_seq_project_mux.sv
// tb/tb_seq_project_mux.sv - directed self-checking bench for seq_project_mux
module tb_seq_project_mux;

  localparam int N_PROJ = 24;
  localparam int ADDR_W = 5;
  localparam int IW_W   = 18;
  localparam int OW_W   = 24;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   ena;
  logic [ADDR_W-1:0]      addr_in;
  logic                   addr_load;
  logic [IW_W-1:0]        iw;
  logic [OW_W-1:0]        ow;
  logic [N_PROJ-1:0]      proj_ena;
  logic [N_PROJ*IW_W-1:0] proj_iw;
  logic [N_PROJ*OW_W-1:0] proj_ow;
  logic [ADDR_W-1:0]      sel_addr;
  logic                   busy;
  logic                   addr_err;

  logic [N_PROJ*IW_W-1:0] exp_iw;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_project_mux dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .addr_in   (addr_in),
    .addr_load (addr_load),
    .iw        (iw),
    .ow        (ow),
    .proj_ena  (proj_ena),
    .proj_iw   (proj_iw),
    .proj_ow   (proj_ow),
    .sel_addr  (sel_addr),
    .busy      (busy),
    .addr_err  (addr_err)
  );

  task automatic check(input string tag, input logic [447:0] got, input logic [447:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a);
    addr_in   = a;
    addr_load = 1'b1;
    tick();
    addr_load = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N_PROJ; k++)
      proj_ow[k*OW_W +: OW_W] = 24'hC00000 + OW_W'(k) * 24'h000101;
    rst_n = 1'b0; ena = 1'b0; addr_in = '0; addr_load = 1'b0; iw = 18'h3FFFF;
    tick(); tick();
    check("rst_ow", ow, 0);
    check("rst_ena", proj_ena, 0);
    check("rst_sel", sel_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_err", addr_err, 0);
    check("rst_iw", proj_iw, 0);

    // 1: load 5, two guard cycles, then enable bit 5, ow one cycle later
    rst_n = 1'b1; ena = 1'b1;
    load(5);
    check("t1_busy1", busy, 1);
    check("t1_ena_g1", proj_ena, 0);
    check("t1_sel", sel_addr, 5);
    tick();
    check("t1_busy2", busy, 1);
    check("t1_ena_g2", proj_ena, 0);
    tick();
    check("t1_busy_end", busy, 0);
    check("t1_ena", proj_ena, 24'h000020);
    check("t1_ow_lat", ow, 0);
    tick();
    check("t1_ow", ow, 24'hC00505);

    // 2: switch to 23, iw only on slot 23
    iw = 18'h2AAAA;
    load(23);
    check("t2_ena_g1", proj_ena, 0);
    tick();
    check("t2_ena_g2", proj_ena, 0);
    check("t2_iw_guard", proj_iw, 0);
    tick();
    check("t2_ena", proj_ena, 24'h800000);
    exp_iw = '0;
    exp_iw[23*IW_W +: IW_W] = 18'h2AAAA;
    check("t2_iw", proj_iw, exp_iw);
    tick();
    check("t2_ow", ow, 24'hC01717);

    // 3: out-of-range load
    load(24);
    check("t3_err", addr_err, 1);
    check("t3_ena", proj_ena, 0);
    check("t3_sel", sel_addr, 23);
    tick();
    check("t3_err_clr", addr_err, 0);
    check("t3_ow", ow, 0);
    check("t3_busy", busy, 0);

    // 4: load 7, reload 9 during guard -> three busy cycles, ends on 9
    load(7);
    check("t4_busy1", busy, 1);
    load(9);
    check("t4_busy2", busy, 1);
    check("t4_sel", sel_addr, 9);
    check("t4_ena_g2", proj_ena, 0);
    tick();
    check("t4_busy3", busy, 1);
    check("t4_ena_g3", proj_ena, 0);
    tick();
    check("t4_busy_end", busy, 0);
    check("t4_ena", proj_ena, 24'h000200);

    // 5: drop ena with a coincident load
    load(3);
    tick(); tick();
    check("t5_ena3", proj_ena, 24'h000008);
    ena = 1'b0;
    load(4);
    check("t5_ena", proj_ena, 0);
    check("t5_err", addr_err, 0);
    check("t5_sel", sel_addr, 3);
    check("t5_busy", busy, 0);
    ena = 1'b1;

    // 6: reload same address in ACTIVE, then reset mid-ACTIVE
    load(3);
    tick(); tick(); tick();
    check("t6_ow", ow, 24'hC00303);
    load(3);
    check("t6_busy", busy, 0);
    check("t6_ena", proj_ena, 24'h000008);
    check("t6_ow_hold", ow, 24'hC00303);
    rst_n = 1'b0;
    tick();
    check("t6_rst_ow", ow, 0);
    check("t6_rst_ena", proj_ena, 0);
    check("t6_rst_sel", sel_addr, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_iw", proj_iw, 0);
    rst_n = 1'b1;
    tick();
    check("t6_post_ena", proj_ena, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
